// File: rtl/ldm_stm_seq_pkg.sv
// Shared types and constants for the LDM/STM block-transfer sequencer.
// Holds the FSM state encoding, width defaults and the register-count helper.
package ldm_stm_seq_pkg;

   localparam int AW_DEF     = 32;
   localparam int DW_DEF     = 32;
   localparam int WORD_BYTES = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_XFER  = 3'd2,
      ST_WB    = 3'd3,
      ST_FIN   = 3'd4
   } seq_state_t;

   function automatic logic [4:0] popcount16(input logic [15:0] vec);
      logic [4:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, vec[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/ldm_stm_seq_prio_enc16.sv
// Lowest-set-bit encoder over a 16-bit register mask.
// o_any flags a non-empty mask; o_index is 0 when the mask is empty.
module prio_enc16
   import ldm_stm_seq_pkg::*;
(
   input  logic [15:0] i_vec,
   output logic [3:0]  o_index,
   output logic        o_any
);

   // Scan downwards so the lowest set bit is the last one to take effect.
   always_comb begin
      o_index = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         o_index = i_vec[i] ? 4'(i) : o_index;
      end
      o_any = |i_vec;
   end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks a register list, moving one word per
// memory handshake between the register file and data memory, then writes back the base.
module ldm_stm_seq
   import ldm_stm_seq_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          start,
   input  logic          is_load,
   input  logic          up,
   input  logic          pre,
   input  logic          wback,
   input  logic [3:0]    base_reg,
   input  logic [AW-1:0] base_addr,
   input  logic [15:0]   reg_list,
   output logic [3:0]    rf_sel_p,
   input  logic [DW-1:0] rf_p_data,
   output logic          rf_we,
   output logic [3:0]    rf_sel_in,
   output logic [DW-1:0] rf_in,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          busy,
   output logic          done,
   output logic          pc_loaded
);

   localparam logic [AW-1:0] STEP = AW'(WORD_BYTES);

   seq_state_t    r_state;
   seq_state_t    w_state_next;
   logic          r_is_load;
   logic          r_up;
   logic          r_pre;
   logic          r_wback;
   logic [3:0]    r_base_reg;
   logic [AW-1:0] r_base;
   logic [15:0]   r_list;
   logic [15:0]   r_mask;
   logic [AW-1:0] r_addr;
   logic [3:0]    r_idx;
   logic          r_busy;
   logic          r_done;
   logic          r_mem_req;
   logic          r_mem_we;
   logic          r_rf_we;
   logic [3:0]    r_rf_sel_in;
   logic [DW-1:0] r_rf_in;
   logic          r_pc_loaded;

   logic [15:0]   w_mask_next;
   logic [AW-1:0] w_addr_next;
   logic [3:0]    w_idx_next;
   logic          w_any_next;
   logic [4:0]    w_n;
   logic [AW-1:0] w_span;
   logic [AW-1:0] w_first;
   logic [AW-1:0] w_final;
   logic          w_xfer_ack;
   logic          w_base_listed;

   prio_enc16 u_prio_enc16 (
      .i_vec   (w_mask_next),
      .o_index (w_idx_next),
      .o_any   (w_any_next)
   );

   // Block geometry: the lowest register always sits at the lowest address.
   assign w_n           = popcount16(r_list);
   assign w_span        = {{(AW-7){1'b0}}, w_n, 2'b00};
   assign w_final       = r_up ? (r_base + w_span) : (r_base - w_span);
   assign w_first       = r_up ? (r_pre ? (r_base + STEP) : r_base)
                               : (r_pre ? (r_base - w_span) : (r_base - w_span + STEP));
   assign w_xfer_ack    = (r_state == ST_XFER) && r_mem_req && mem_ack;
   assign w_base_listed = r_is_load && r_list[r_base_reg];

   // Next remaining-mask and transfer address.
   always_comb begin
      w_mask_next = r_mask;
      w_addr_next = r_addr;
      case (r_state)
         ST_IDLE: begin
            w_mask_next = start ? reg_list : r_mask;
         end
         ST_SETUP: begin
            w_addr_next = w_first;
         end
         ST_XFER: begin
            if (w_xfer_ack) begin
               w_mask_next = r_mask & ~(16'd1 << r_idx);
               w_addr_next = r_addr + STEP;
            end else begin
               w_mask_next = r_mask;
               w_addr_next = r_addr;
            end
         end
         default: begin
            w_mask_next = r_mask;
            w_addr_next = r_addr;
         end
      endcase
   end

   // Next-state decode; an empty list goes straight from SETUP to FIN.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  w_state_next = start ? ST_SETUP : ST_IDLE;
         ST_SETUP: w_state_next = (w_n == 5'd0) ? ST_FIN : ST_XFER;
         ST_XFER:  w_state_next = (w_xfer_ack && !w_any_next) ? ST_WB : ST_XFER;
         ST_WB:    w_state_next = ST_FIN;
         ST_FIN:   w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Operation parameters captured once at launch.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_is_load  <= 1'b0;
         r_up       <= 1'b0;
         r_pre      <= 1'b0;
         r_wback    <= 1'b0;
         r_base_reg <= 4'd0;
         r_base     <= {AW{1'b0}};
         r_list     <= 16'd0;
      end else if ((r_state == ST_IDLE) && start) begin
         r_is_load  <= is_load;
         r_up       <= up;
         r_pre      <= pre;
         r_wback    <= wback;
         r_base_reg <= base_reg;
         r_base     <= base_addr;
         r_list     <= reg_list;
      end
   end

   // Walking mask, current address and the register it selects.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_mask <= 16'd0;
         r_addr <= {AW{1'b0}};
         r_idx  <= 4'd0;
      end else begin
         r_mask <= w_mask_next;
         r_addr <= w_addr_next;
         r_idx  <= w_idx_next;
      end
   end

   // Registered handshake/status outputs, aligned with the state they describe.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_mem_req <= 1'b0;
         r_mem_we  <= 1'b0;
      end else begin
         r_busy    <= (w_state_next != ST_IDLE);
         r_done    <= (w_state_next == ST_FIN);
         r_mem_req <= (w_state_next == ST_XFER);
         r_mem_we  <= (w_state_next == ST_XFER) && !r_is_load;
      end
   end

   // Write port: loaded words land the cycle after their ack; the base write
   // follows WB so it never collides with the final loaded word.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rf_we     <= 1'b0;
         r_rf_sel_in <= 4'd0;
         r_rf_in     <= {DW{1'b0}};
         r_pc_loaded <= 1'b0;
      end else if (w_xfer_ack && r_is_load) begin
         r_rf_we     <= 1'b1;
         r_rf_sel_in <= r_idx;
         r_rf_in     <= mem_rdata;
         r_pc_loaded <= (r_idx == 4'd15);
      end else if ((r_state == ST_WB) && r_wback && !w_base_listed) begin
         r_rf_we     <= 1'b1;
         r_rf_sel_in <= r_base_reg;
         r_rf_in     <= DW'(w_final);
         r_pc_loaded <= 1'b0;
      end else begin
         r_rf_we     <= 1'b0;
         r_rf_sel_in <= 4'd0;
         r_rf_in     <= {DW{1'b0}};
         r_pc_loaded <= 1'b0;
      end
   end

   assign rf_sel_p  = r_idx;
   assign rf_we     = r_rf_we;
   assign rf_sel_in = r_rf_sel_in;
   assign rf_in     = r_rf_in;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = (r_mem_req && r_mem_we) ? rf_p_data : {DW{1'b0}};
   assign busy      = r_busy;
   assign done      = r_done;
   assign pc_loaded = r_pc_loaded;

endmodule
